dadda_mac_accum: RTL

Sequential accumulate stage directly downstream of the 8x8 Dadda multiplier. It consumes the multiplier's 16-bit unsigned product (15 product bits plus the overflow bit as MSB) through a valid/ready handshake. It sums a programmed number of products into a wide accumulator and presents the total with an output handshake. Together with the combinational multiplier it forms the team's multiply-accumulate datapath.

---
 rtl/dadda_mac_accum.sv | 74 +++++++
 1 files changed

// File: rtl/dadda_mac_accum.sv
// dadda_mac_accum: sums a programmed count of Dadda multiplier products behind valid/ready handshakes.
// Define DADDA_MAC_SATURATE_EN to clamp at the accumulator maximum instead of wrapping.
module dadda_mac_accum #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PROD_WIDTH-1:0] prod,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_WIDTH-1:0]  acc_out,
   output logic                  sat,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state, next_state;
   logic [LEN_WIDTH-1:0] rem;
   logic [ACC_WIDTH-1:0] acc_next;
   logic accept, take;
   assign accept = state == IDLE && start;
   assign take = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next_state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = len == '0 ? DONE : ACCUM;
         ACCUM:   if (take && rem == LEN_WIDTH'(1)) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready = state == ACCUM;
      out_valid = state == DONE;
      busy = state != IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc_out <= '0;
         rem <= '0;
      end else if (accept) begin
         acc_out <= '0;
         rem <= len;
      end else if (take) begin
         acc_out <= acc_next;
         rem <= rem - LEN_WIDTH'(1);
      end

`ifdef DADDA_MAC_SATURATE_EN
   // The extra sum bit is the carry; once clamped, any further nonzero product carries again.
   logic [ACC_WIDTH:0] sum;
   assign sum = {1'b0, acc_out} + (ACC_WIDTH+1)'(prod);
   assign acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sat <= 1'b0;
      else if (accept) sat <= 1'b0;
      else if (take && sum[ACC_WIDTH]) sat <= 1'b1;
`else
   assign acc_next = acc_out + ACC_WIDTH'(prod);
   assign sat = 1'b0;
`endif
endmodule
